// File: rtl/xge_tx_pkg.sv
// Shared types and constants for the xge_mac transmit feeder.
package xge_tx_pkg;

    localparam int unsigned JUMBO_WORDS = 1190;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
        logic [2:0]  mod;
    } tx_word_t;

    typedef enum logic {
        IN_ACCEPT,
        IN_DROP
    } in_state_t;

    // Saturating 16-bit increment used by the truncation counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/xge_tx_fifo_sync.sv
// Single-clock show-ahead FIFO of tx_word_t; head entry is readable without a pop.
module xge_tx_fifo_sync
    import xge_tx_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  tx_word_t                    wr_data,
    input  logic                        rd_en,
    output tx_word_t                    rd_data,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        full,
    output logic                        empty
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    tx_word_t        mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_wr;
    logic            do_rd;

    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;
    assign rd_data = mem[rd_ptr];

    // Storage array; no reset needed since occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-2 depth).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/xge_tx_feeder.sv
// Upstream feeder for the xge_mac transmit path: buffers valid/ready frame words,
// truncates oversize frames, and drives pkt_tx_* with generated sop/eop.
module xge_tx_feeder
    import xge_tx_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned MAX_WORDS  = JUMBO_WORDS
) (
    input  logic        clk_156m25,
    input  logic        reset_156m25,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic        in_last,
    input  logic [2:0]  in_mod,
    output logic [63:0] pkt_tx_data,
    output logic        pkt_tx_val,
    output logic        pkt_tx_sop,
    output logic        pkt_tx_eop,
    output logic [2:0]  pkt_tx_mod,
    input  logic        pkt_tx_full,
    output logic [31:0] frames_sent,
    output logic [15:0] frames_trunc
);

    localparam int unsigned WCNT_W = $clog2(MAX_WORDS + 1);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

    in_state_t         state;
    in_state_t         state_nx;
    logic [WCNT_W-1:0] wcnt;
    logic [WCNT_W-1:0] wcnt_nx;
    logic              accept;
    logic              fifo_wr;
    tx_word_t          fifo_wdata;
    tx_word_t          fifo_rdata;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              trunc_hit;
    logic              pop;
    logic              out_in_frame;

    // Ready is forced low while reset is held; drop mode always sinks words.
    assign in_ready = ~reset_156m25 &
                      ((fifo_count < CNT_W'(FIFO_DEPTH)) | (state == IN_DROP));
    assign accept   = in_valid & in_ready;
    assign pop      = ~pkt_tx_full & ~fifo_empty;

    xge_tx_fifo_sync #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_156m25),
        .rst     (reset_156m25),
        .wr_en   (fifo_wr),
        .wr_data (fifo_wdata),
        .rd_en   (pop),
        .rd_data (fifo_rdata),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Input FSM state and per-frame word counter.
    always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
        if (reset_156m25) begin
            state <= IN_ACCEPT;
            wcnt  <= '0;
        end else begin
            state <= state_nx;
            wcnt  <= wcnt_nx;
        end
    end

    // Input FSM next state: write words, or cut the frame at MAX_WORDS and drop its tail.
    always_comb begin
        state_nx        = state;
        wcnt_nx         = wcnt;
        fifo_wr         = 1'b0;
        trunc_hit       = 1'b0;
        fifo_wdata.data = in_data;
        fifo_wdata.last = in_last;
        fifo_wdata.mod  = in_last ? in_mod : 3'd0;
        case (state)
            IN_ACCEPT: begin
                if (accept && !fifo_full) begin
                    fifo_wr = 1'b1;
                    if (in_last) begin
                        wcnt_nx = '0;
                    end else if (wcnt == WCNT_W'(MAX_WORDS - 1)) begin
                        // Final allowed word becomes a full-width eop; rest of frame is discarded.
                        fifo_wdata.last = 1'b1;
                        fifo_wdata.mod  = 3'd0;
                        trunc_hit       = 1'b1;
                        wcnt_nx         = '0;
                        state_nx        = IN_DROP;
                    end else begin
                        wcnt_nx = wcnt + WCNT_W'(1);
                    end
                end
            end
            IN_DROP: begin
                if (accept && in_last) begin
                    wcnt_nx  = '0;
                    state_nx = IN_ACCEPT;
                end
            end
            default: begin
                state_nx = IN_ACCEPT;
                wcnt_nx  = '0;
            end
        endcase
    end

    // Registered output stage with sop tracking and sent-frame counter.
    always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
        if (reset_156m25) begin
            pkt_tx_val   <= 1'b0;
            pkt_tx_data  <= '0;
            pkt_tx_sop   <= 1'b0;
            pkt_tx_eop   <= 1'b0;
            pkt_tx_mod   <= '0;
            out_in_frame <= 1'b0;
            frames_sent  <= '0;
        end else if (pop) begin
            pkt_tx_val   <= 1'b1;
            pkt_tx_data  <= fifo_rdata.data;
            pkt_tx_sop   <= ~out_in_frame;
            pkt_tx_eop   <= fifo_rdata.last;
            pkt_tx_mod   <= fifo_rdata.last ? fifo_rdata.mod : 3'd0;
            out_in_frame <= ~fifo_rdata.last;
            if (fifo_rdata.last) begin
                frames_sent <= frames_sent + 32'd1;
            end
        end else begin
            pkt_tx_val  <= 1'b0;
            pkt_tx_data <= '0;
            pkt_tx_sop  <= 1'b0;
            pkt_tx_eop  <= 1'b0;
            pkt_tx_mod  <= '0;
        end
    end

    // Saturating count of frames cut at MAX_WORDS.
    always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
        if (reset_156m25) begin
            frames_trunc <= '0;
        end else if (trunc_hit) begin
            frames_trunc <= sat_inc16(frames_trunc);
        end
    end

endmodule

// File: tb/tb_xge_tx_feeder.sv
// Randomized self-checking bench for xge_tx_feeder against a queue-based reference model.
module tb_xge_tx_feeder;
    import xge_tx_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned MAXW  = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic        in_last = 1'b0;
    logic [2:0]  in_mod = '0;
    logic [63:0] pkt_tx_data;
    logic        pkt_tx_val;
    logic        pkt_tx_sop;
    logic        pkt_tx_eop;
    logic [2:0]  pkt_tx_mod;
    logic        pkt_tx_full = 1'b0;
    logic [31:0] frames_sent;
    logic [15:0] frames_trunc;

    xge_tx_feeder #(
        .FIFO_DEPTH (DEPTH),
        .MAX_WORDS  (MAXW)
    ) dut (
        .clk_156m25   (clk),
        .reset_156m25 (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_mod       (in_mod),
        .pkt_tx_data  (pkt_tx_data),
        .pkt_tx_val   (pkt_tx_val),
        .pkt_tx_sop   (pkt_tx_sop),
        .pkt_tx_eop   (pkt_tx_eop),
        .pkt_tx_mod   (pkt_tx_mod),
        .pkt_tx_full  (pkt_tx_full),
        .frames_sent  (frames_sent),
        .frames_trunc (frames_trunc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference model: FIFO contents as a queue, frame truncation by word number.
    tx_word_t    fq[$];
    tx_word_t    w;
    bit          m_drop, m_in_frame, m_rdy, m_pop;
    int          m_wc;
    logic        exp_val, exp_sop, exp_eop;
    logic [63:0] exp_data;
    logic [2:0]  exp_mod;
    logic [31:0] m_sent;
    logic [15:0] m_trunc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fq.delete();
            m_drop = 0; m_in_frame = 0; m_wc = 0;
            exp_val = 0; exp_sop = 0; exp_eop = 0; exp_data = '0; exp_mod = '0;
            m_sent = '0; m_trunc = '0;
        end else begin
            m_rdy = (fq.size() < DEPTH) || m_drop;
            m_pop = !pkt_tx_full && (fq.size() != 0);
            exp_val = 0; exp_sop = 0; exp_eop = 0; exp_data = '0; exp_mod = '0;
            if (m_pop) begin
                w = fq.pop_front();
                exp_val  = 1;
                exp_data = w.data;
                exp_sop  = !m_in_frame;
                exp_eop  = w.last;
                exp_mod  = w.last ? w.mod : 3'd0;
                m_in_frame = !w.last;
                if (w.last) m_sent++;
            end
            if (in_valid && m_rdy) begin
                if (m_drop) begin
                    if (in_last) m_drop = 0;
                end else begin
                    m_wc++;
                    if (in_last) begin
                        fq.push_back(tx_word_t'{data: in_data, last: 1'b1, mod: in_mod});
                        m_wc = 0;
                    end else if (m_wc == MAXW) begin
                        fq.push_back(tx_word_t'{data: in_data, last: 1'b1, mod: 3'd0});
                        m_wc = 0;
                        m_drop = 1;
                        if (m_trunc != 16'hFFFF) m_trunc++;
                    end else begin
                        fq.push_back(tx_word_t'{data: in_data, last: 1'b0, mod: 3'd0});
                    end
                end
            end
        end
    end

    int val_seen = 0, sop_seen = 0, eop_seen = 0, run = 0, max_run = 0;

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        chk("in_ready", in_ready, rst ? 1'b0 : ((fq.size() < DEPTH) || m_drop));
        chk("val", pkt_tx_val, exp_val);
        chk("data", pkt_tx_data, exp_data);
        chk("sop", pkt_tx_sop, exp_sop);
        chk("eop", pkt_tx_eop, exp_eop);
        chk("mod", pkt_tx_mod, exp_mod);
        chk("frames_sent", frames_sent, m_sent);
        chk("frames_trunc", frames_trunc, m_trunc);
        if (pkt_tx_val) begin
            val_seen++; run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
        if (pkt_tx_val && pkt_tx_sop) sop_seen++;
        if (pkt_tx_val && pkt_tx_eop) eop_seen++;
    end

    // Source side
    tx_word_t src_q[$];
    int  vpct = 100, full_pct = 0, acc_cnt = 0;
    bit  force_full = 0;

    task automatic add_frame(input int n, input logic [2:0] mod);
        for (int i = 0; i < n; i++) begin
            tx_word_t t;
            t.data = {$urandom, $urandom};
            t.last = (i == n - 1);
            t.mod  = (i == n - 1) ? mod : 3'($urandom);
            src_q.push_back(t);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
        pkt_tx_full = force_full ? 1'b1 : ($urandom_range(99) < full_pct);
        if (src_q.size() > 0 && $urandom_range(99) < vpct) begin
            in_valid = 1'b1;
            in_data  = src_q[0].data;
            in_last  = src_q[0].last;
            in_mod   = src_q[0].mod;
        end else begin
            in_valid = 1'b0;
            in_data  = {$urandom, $urandom};
            in_last  = 1'($urandom);
            in_mod   = 3'($urandom);
        end
        if (in_valid && in_ready) begin
            void'(src_q.pop_front());
            acc_cnt++;
        end
    endtask

    task automatic drain(input int max_cycles);
        int k = 0;
        while ((src_q.size() > 0 || in_valid || fq.size() > 0 || exp_val) && k < max_cycles) begin
            step();
            k++;
        end
        if (k >= max_cycles) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got=%0d expected=<%0d cycles", k, max_cycles);
        end
    endtask

    int v0, s0, e0, a0;

    initial begin
        repeat (3) @(negedge clk);
        chk("ready_in_reset", in_ready, 1'b0);
        #1 rst = 1'b0;
        #1 chk("ready_after_reset", in_ready, 1'b1);

        // Single-word frame with literal expectations, including one-cycle latency.
        src_q.push_back(tx_word_t'{data: 64'h0011223344556677, last: 1'b1, mod: 3'd4});
        step();
        step();
        chk("lat_val_early", pkt_tx_val, 1'b0);
        step();
        chk("one_val", pkt_tx_val, 1'b1);
        chk("one_data", pkt_tx_data, 64'h0011223344556677);
        chk("one_sop", pkt_tx_sop, 1'b1);
        chk("one_eop", pkt_tx_eop, 1'b1);
        chk("one_mod", pkt_tx_mod, 3'd4);
        chk("one_sent", frames_sent, 32'd1);
        drain(50);

        // Three back-to-back 8-word frames.
        v0 = val_seen; s0 = sop_seen; e0 = eop_seen; max_run = 0;
        repeat (3) add_frame(8, 3'd0);
        drain(200);
        chk("b2b_vals", val_seen - v0, 24);
        chk("b2b_run", max_run, 24);
        chk("b2b_sops", sop_seen - s0, 3);
        chk("b2b_eops", eop_seen - e0, 3);

        // Back-pressure for five cycles mid-frame.
        v0 = val_seen;
        add_frame(8, 3'd6);
        repeat (4) step();
        force_full = 1;
        repeat (5) step();
        force_full = 0;
        drain(200);
        chk("bp_vals", val_seen - v0, 8);

        // Truncation: 12-word frame cut at 10, then 2-word frame, then exact 10-word frame.
        v0 = val_seen; e0 = eop_seen;
        add_frame(12, 3'd5);
        add_frame(2, 3'd3);
        drain(200);
        chk("trunc_cnt", frames_trunc, 16'd1);
        chk("trunc_vals", val_seen - v0, 12);
        chk("trunc_eops", eop_seen - e0, 2);
        v0 = val_seen;
        add_frame(10, 3'd2);
        drain(200);
        chk("exact_max_trunc", frames_trunc, 16'd1);
        chk("exact_max_vals", val_seen - v0, 10);

        // Held full: 20 words offered, 16 fit.
        a0 = acc_cnt; v0 = val_seen;
        force_full = 1;
        add_frame(10, 3'd1);
        add_frame(10, 3'd7);
        repeat (30) step();
        chk("full_accepted", acc_cnt - a0, 16);
        chk("full_ready", in_ready, 1'b0);
        force_full = 0;
        drain(200);
        chk("full_vals", val_seen - v0, 20);

        // Random traffic with random back-pressure.
        vpct = 70; full_pct = 20;
        for (int f = 0; f < 60; f++) add_frame($urandom_range(14, 1), 3'($urandom));
        drain(5000);

        // Reset in the middle of a frame.
        vpct = 100; full_pct = 0;
        add_frame(8, 3'd0);
        repeat (3) step();
        @(negedge clk);
        #1 rst = 1'b1;
        src_q.delete();
        in_valid = 1'b0;
        #1;
        chk("rst_val", pkt_tx_val, 1'b0);
        chk("rst_data", pkt_tx_data, 64'd0);
        chk("rst_sent", frames_sent, 32'd0);
        chk("rst_trunc", frames_trunc, 16'd0);
        chk("rst_ready", in_ready, 1'b0);
        @(negedge clk);
        #1 rst = 1'b0;
        s0 = sop_seen;
        add_frame(3, 3'd1);
        drain(100);
        chk("post_rst_sent", frames_sent, 32'd1);
        chk("post_rst_sops", sop_seen - s0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
